// File: rtl/tensor_core_load_controller.sv
// Load sequencer for the tensor core: fills both 3x3 operand matrices from a
// byte stream, kicks the core, waits for completion and streams matrix 0 back.
// Uses only the register file's quad-write, non-bulk-write and dual-read ports.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_in
// ST_LOAD  | accepting operand bytes 0..17 into the register file
// ST_START | lets the last write commit, then pulses compute_start_out
// ST_WAIT  | waiting for compute_done_in, bounded by COMPUTE_TIMEOUT
// ST_DRAIN | streaming result elements 0..8 via the dual-read port
module tensor_core_load_controller #(
  parameter int DATA_WIDTH      = 8,
  parameter int COMPUTE_TIMEOUT = 64
) (
  input  logic                      clock_in,
  input  logic                      reset_n_in,
  input  logic                      start_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      error_out,
  input  logic                      in_valid_in,
  output logic                      in_ready_out,
  input  logic [DATA_WIDTH-1:0]     in_data_in,
  output logic                      out_valid_out,
  input  logic                      out_ready_in,
  output logic [DATA_WIDTH-1:0]     out_data_out,
  output logic                      rf_quad_write_enable_out,
  output logic [2:0]                rf_quad_write_address_out,
  output logic [4*DATA_WIDTH-1:0]   rf_quad_write_data_out,
  output logic                      rf_non_bulk_write_enable_out,
  output logic [4:0]                rf_non_bulk_write_address_out,
  output logic [DATA_WIDTH-1:0]     rf_non_bulk_write_data_out,
  output logic [3:0]                rf_dual_read_address_out,
  input  logic [2*DATA_WIDTH-1:0]   rf_dual_read_data_in,
  output logic                      compute_start_out,
  input  logic                      compute_done_in
);

  localparam int TW = (COMPUTE_TIMEOUT > 1) ? $clog2(COMPUTE_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_DRAIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_busy, r_done, r_error, r_cs;
  logic                    w_done_nxt, w_error_nxt, w_cs_nxt;
  logic [4:0]              r_ec;
  logic [3:0]              r_ri;
  logic [TW-1:0]           r_tcnt;
  logic [DATA_WIDTH-1:0]   r_buf0, r_buf1, r_buf2;
  logic                    r_qwe, r_nbwe;
  logic [2:0]              r_qaddr;
  logic [4*DATA_WIDTH-1:0] r_qdata;
  logic [4:0]              r_nbaddr;
  logic [DATA_WIDTH-1:0]   r_nbdata;
  logic                    w_in_hs, w_out_hs, w_timeout;

  assign w_in_hs   = (r_state == ST_LOAD) && in_valid_in;
  assign w_out_hs  = (r_state == ST_DRAIN) && out_ready_in;
  assign w_timeout = (COMPUTE_TIMEOUT != 0) && (r_tcnt == TW'(COMPUTE_TIMEOUT));

  // Next-state and next values of the registered status pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    w_cs_nxt    = 1'b0;
    case (r_state)
      ST_IDLE:  if (start_in) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_in_hs && (r_ec == 5'd17)) w_state_nxt = ST_START;
      // First START cycle carries the element-17 write; pulse on the second.
      ST_START: begin
        w_cs_nxt = !r_cs;
        if (r_cs) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (compute_done_in) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_out_hs && (r_ri == 4'd8)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_cs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_cs    <= w_cs_nxt;
    end
  end

  // Counters, lane buffer and register-file write port registers.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_ec     <= '0;
      r_ri     <= '0;
      r_tcnt   <= '0;
      r_buf0   <= '0;
      r_buf1   <= '0;
      r_buf2   <= '0;
      r_qwe    <= 1'b0;
      r_qaddr  <= '0;
      r_qdata  <= '0;
      r_nbwe   <= 1'b0;
      r_nbaddr <= '0;
      r_nbdata <= '0;
    end else begin
      r_qwe  <= 1'b0;
      r_nbwe <= 1'b0;
      if ((r_state == ST_IDLE) && start_in) begin
        r_ec   <= '0;
        r_ri   <= '0;
        r_tcnt <= '0;
      end
      if (w_in_hs) begin
        r_ec <= r_ec + 5'd1;
        case (r_ec[1:0])
          2'd0:    r_buf0 <= in_data_in;
          2'd1:    r_buf1 <= in_data_in;
          2'd2:    r_buf2 <= in_data_in;
          default: ;
        endcase
        // Elements 16/17 have no full quad behind them, so they go non-bulk.
        if (r_ec[4]) begin
          r_nbwe   <= 1'b1;
          r_nbaddr <= r_ec;
          r_nbdata <= in_data_in;
        end else if (r_ec[1:0] == 2'd3) begin
          r_qwe   <= 1'b1;
          r_qaddr <= r_ec[4:2];
          r_qdata <= {in_data_in, r_buf2, r_buf1, r_buf0};
        end
      end
      if (r_state == ST_WAIT) r_tcnt <= r_tcnt + TW'(1);
      if (w_out_hs) r_ri <= r_ri + 4'd1;
    end
  end

  assign busy_out                      = r_busy;
  assign done_out                      = r_done;
  assign error_out                     = r_error;
  assign compute_start_out             = r_cs;
  assign rf_quad_write_enable_out      = r_qwe;
  assign rf_quad_write_address_out     = r_qaddr;
  assign rf_quad_write_data_out        = r_qdata;
  assign rf_non_bulk_write_enable_out  = r_nbwe;
  assign rf_non_bulk_write_address_out = r_nbaddr;
  assign rf_non_bulk_write_data_out    = r_nbdata;
  assign in_ready_out                  = (r_state == ST_LOAD);
  assign out_valid_out                 = (r_state == ST_DRAIN);
  assign rf_dual_read_address_out      = (r_state == ST_DRAIN) ? {1'b0, r_ri[3:1]} : 4'd0;
  assign out_data_out                  = (r_state != ST_DRAIN) ? '0 :
                                         r_ri[0] ? rf_dual_read_data_in[2*DATA_WIDTH-1:DATA_WIDTH]
                                                 : rf_dual_read_data_in[DATA_WIDTH-1:0];

endmodule

// File: doc/tensor_core_load_controller.md
# tensor_core_load_controller

Sequencer that loads both 3x3 operand matrices of the tensor core register file from a byte stream, triggers the tensor core, and streams the 3x3 result back out. It sits between the host-side byte interface and the register file / tensor core pair, driving the register file's quad-write, non-bulk-write and dual-read ports. It never touches the register file's bulk ports; those belong to the tensor core.

## Interface
Parameters:
- DATA_WIDTH, 8, element width; must match the register file element width.
- COMPUTE_TIMEOUT, 64, maximum cycles to wait for compute_done_in; 0 disables the timeout.

Ports:
- clock_in  in  1  single clock, rising edge.
- reset_n_in  in  1  asynchronous, active-low reset.
- start_in  in  1  one-cycle request to begin a job; honoured only in IDLE.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse when the last result byte is accepted.
- error_out  out  1  one-cycle pulse on compute timeout.
- in_valid_in / in_ready_out / in_data_in  in/out/in  1/1/DATA_WIDTH  operand byte stream, signed.
- out_valid_out / out_ready_in / out_data_out  out/in/out  1/1/DATA_WIDTH  result byte stream, signed.
- rf_quad_write_enable_out  out  1; rf_quad_write_address_out  out  3; rf_quad_write_data_out  out  4 x DATA_WIDTH.
- rf_non_bulk_write_enable_out  out  1; rf_non_bulk_write_address_out  out  5; rf_non_bulk_write_data_out  out  DATA_WIDTH.
- rf_dual_read_address_out  out  4; rf_dual_read_data_in  in  2 x DATA_WIDTH, combinational from the register file.
- compute_start_out  out  1  one-cycle pulse to the tensor core.
- compute_done_in  in  1  tensor core has written the result into matrix 0.

## Operation
- Element index e = n*9 + row*3 + col, row-major, matrix 0 first. Operand bytes arrive in e order 0..17. Results are read from matrix 0 and sent in order 0..8.
- States: IDLE, LOAD, START, WAIT, DRAIN.
- IDLE: in_ready_out=0 and out_valid_out=0. start_in moves to LOAD and clears the element counter ec, the read index ri, and the timeout counter.
- LOAD: in_ready_out=1.
  - Each handshake stores the byte in lane ec%4 of a 4-entry buffer and increments ec.
  - Accepting element ec=4q+3 (q=0..3) registers a quad write: address q, data = buffer lanes 0..2 plus the current byte in lane 3.
  - Elements 16 and 17 each register a non-bulk write at address 16 or 17. Quad writes are never used for q=4, because indices 18 and 19 do not exist.
  - Accepting element 17 moves to START.
- START: compute_start_out=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - compute_done_in sampled high moves to DRAIN.
  - If COMPUTE_TIMEOUT≠0 and the counter reaches COMPUTE_TIMEOUT first: error_out pulses and the state returns to IDLE with no output bytes.
- DRAIN:
  - Outputs: out_valid_out=1, rf_dual_read_address_out=ri>>1, out_data_out=rf_dual_read_data_in[ri&1].
  - Each handshake increments ri. The handshake at ri=8 pulses done_out and returns to IDLE. Lane 1 of address 4 (element 9) is never emitted.
- At most one of the rf write enables is high in any cycle. rf write address and data outputs hold their last value when the enable is low.
- Inputs ignored: start_in outside IDLE; compute_done_in outside WAIT; in_valid_in outside LOAD.
- Reset: asynchronous. Returns to IDLE and zeroes every output, the buffer, and all counters, including mid-job. Partial register-file contents are left as they are.

## Timing
- All outputs are registered except these, which are combinational from state/ri and the rf read data:
  - in_ready_out
  - out_valid_out
  - out_data_out
  - rf_dual_read_address_out
- Byte accepted at edge t: the corresponding rf write enable is high during cycle t+1 and the register file commits at the end of t+1.
- Element 17 accepted at edge t: non-bulk write during t+1 (state START). compute_start_out is high during t+2, after the write has committed. WAIT begins at t+3.
- LOAD sustains one byte per cycle with no bubbles. Minimum job length: 1 (start) + 18 + 2 + 1 (done) + 9 cycles, excluding compute latency.
- Timeout counter increments every cycle in WAIT, starting at 0 on entry. error_out fires in the cycle after the count reaches COMPUTE_TIMEOUT with compute_done_in still low.

## Test plan
- Fill, back-to-back: start, then bytes 1..18 with in_valid held high. Expect:
  - quad writes addr 0..3 with data {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}, each one cycle after its 4th byte;
  - non-bulk writes 16←17 and 17←18;
  - compute_start_out exactly 2 cycles after byte 18.
- Signed values and input gaps: bytes -128, 127, -1, ... with random in_valid gaps. Write data matches bit-exactly and no write is issued during a gap.
- Readout with backpressure: register file model holds matrix 0 = -4..4, compute_done_in given 5 cycles after start pulse, random out_ready_in. Expect 9 bytes -4..4 in order, dual-read address stepping 0,0,1,1,..,4, done_out on the 9th handshake, busy_out low the next cycle.
- Timeout: COMPUTE_TIMEOUT=8 and compute_done_in never asserted. Expect one error_out pulse 9 cycles after WAIT entry, return to IDLE, and out_valid_out never high.
- Reset and ignored inputs:
  - assert reset_n_in low mid-LOAD after 7 bytes: all outputs drop to 0 immediately, and a new start followed by 18 bytes runs a normal job from e=0;
  - start_in pulsed during WAIT and DRAIN has no effect.
